// File: rtl/rank_converge_check.sv
// rank_converge_check: streaming PageRank convergence check with top-rank tracking.
module rank_converge_check #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] thr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_old,
  input  logic [DATA_W-1:0] in_new,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [DATA_W-1:0] max_delta,
  output logic [IDX_W-1:0]  top_idx,
  output logic [DATA_W-1:0] top_rank,
  output logic [IDX_W-1:0]  node_count,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_thr, r_max, r_top_rank, w_delta, w_max_next;
  logic [IDX_W-1:0]  r_idx, r_top_idx;
  logic              r_ovf, r_conv, w_clear, w_acc;
  always_comb begin
    in_ready   = (r_state == ACCUM) && !start;
    w_acc      = in_valid && in_ready;
    w_clear    = start && (r_state != REPORT);
    w_delta    = (in_new >= in_old) ? in_new - in_old : in_old - in_new;
    w_max_next = (w_acc && (w_delta > r_max)) ? w_delta : r_max;
    w_next     = (r_state == IDLE)  ? (start ? ACCUM : IDLE) :
                 (r_state == ACCUM) ? ((w_acc && in_last) ? REPORT : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_thr      <= '0;
      r_max      <= '0;
      r_top_rank <= '0;
      r_top_idx  <= '0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_conv     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_thr      <= thr;
        r_max      <= '0;
        r_top_rank <= '0;
        r_top_idx  <= '0;
        r_idx      <= '0;
        r_ovf      <= 1'b0;
        r_conv     <= 1'b0;
      end else if (w_acc) begin
        r_max <= w_max_next;
        if (in_new > r_top_rank) begin
          r_top_rank <= in_new;
          r_top_idx  <= r_idx;
        end
        r_idx <= r_idx + 1'b1;
        if (&r_idx) r_ovf <= 1'b1;
        if (in_last) r_conv <= (w_max_next <= r_thr);
      end
    end
  end
  // node_count and the running index advance in lockstep, so one register serves both
  assign busy       = (r_state == ACCUM);
  assign done       = (r_state == REPORT);
  assign converged  = r_conv;
  assign max_delta  = r_max;
  assign top_idx    = r_top_idx;
  assign top_rank   = r_top_rank;
  assign node_count = r_idx;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_rank_converge_check.sv
// tb_rank_converge_check: directed scoreboard bench for rank_converge_check.
module tb_rank_converge_check;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [31:0] thr, in_old, in_new;
  logic        in_ready, busy, done, converged, overflow;
  logic [31:0] max_delta, top_rank;
  logic [9:0]  top_idx, node_count;
  typedef struct {
    logic        conv;
    logic [31:0] maxd;
    logic [9:0]  tidx;
    logic [31:0] trank;
    logic [9:0]  ncnt;
    logic        ovf;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int   checks = 0, errors = 0, dones = 0;
  logic prev_done = 1'b0;
  rank_converge_check dut (
    .clk(clk), .rst(rst), .start(start), .thr(thr), .in_valid(in_valid),
    .in_ready(in_ready), .in_old(in_old), .in_new(in_new), .in_last(in_last),
    .busy(busy), .done(done), .converged(converged), .max_delta(max_delta),
    .top_idx(top_idx), .top_rank(top_rank), .node_count(node_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        me = q.pop_front();
        chk("converged", {31'b0, converged}, {31'b0, me.conv});
        chk("max_delta", max_delta, me.maxd);
        chk("top_idx", {22'b0, top_idx}, {22'b0, me.tidx});
        chk("top_rank", top_rank, me.trank);
        chk("node_count", {22'b0, node_count}, {22'b0, me.ncnt});
        chk("overflow", {31'b0, overflow}, {31'b0, me.ovf});
        chk("busy_in_report", {31'b0, busy}, 32'd0);
      end
    end
    if (!rst && prev_done) chk("done_width", {31'b0, done}, 32'd0);
    prev_done = done && !rst;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_start(input logic [31:0] t);
    idle(1);
    start = 1'b1;
    thr   = t;
    idle(1);
    start = 1'b0;
  endtask
  task automatic beat(input logic [31:0] o, input logic [31:0] n, input logic l);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_old   = o;
    in_new   = n;
    in_last  = l;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic gap(input int n);
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_new   = 32'hFFFF_FFFF;
    in_old   = 32'h0;
    idle(n);
    in_last  = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; thr = '0; in_valid = 1'b0; in_old = '0; in_new = '0; in_last = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_converged", {31'b0, converged}, 32'd0);
    chk("rst_max_delta", max_delta, 32'd0);
    chk("rst_top_idx", {22'b0, top_idx}, 32'd0);
    chk("rst_top_rank", top_rank, 32'd0);
    chk("rst_node_count", {22'b0, node_count}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // basic vector, not converged
    q.push_back('{1'b0, 32'h28000, 10'd2, 32'h30000, 10'd3, 1'b0});
    do_start(32'h100);
    chk("idle_to_accum_busy", {31'b0, busy}, 32'd1);
    beat(32'h10000, 32'h10080, 1'b0);
    beat(32'h20000, 32'h1FF00, 1'b0);
    beat(32'h08000, 32'h30000, 1'b1);
    @(negedge clk);
    chk("done_latency", {31'b0, done}, 32'd1);
    // inclusive threshold boundary
    q.push_back('{1'b1, 32'h100, 10'd0, 32'h5010, 10'd2, 1'b0});
    do_start(32'h100);
    beat(32'h5000, 32'h5010, 1'b0);
    beat(32'h5000, 32'h4F00, 1'b1);
    // tie on top rank keeps the earliest index
    q.push_back('{1'b1, 32'h0, 10'd1, 32'h9000, 10'd3, 1'b0});
    do_start(32'h0);
    beat(32'h7000, 32'h7000, 1'b0);
    beat(32'h9000, 32'h9000, 1'b0);
    beat(32'h9000, 32'h9000, 1'b1);
    // single-beat vector
    q.push_back('{1'b1, 32'h100, 10'd0, 32'h200, 10'd1, 1'b0});
    do_start(32'h100);
    beat(32'h100, 32'h200, 1'b1);
    // gaps, then restart while a beat is presented
    do_start(32'h10);
    gap($urandom_range(1, 3));
    beat(32'h0, 32'h50000, 1'b0);
    gap($urandom_range(1, 3));
    beat(32'h40000, 32'h0, 1'b0);
    gap($urandom_range(0, 2));
    chk("pre_restart_count", {22'b0, node_count}, 32'd2);
    in_valid = 1'b1; in_old = 32'h0; in_new = 32'hFFFF0000; in_last = 1'b1;
    start = 1'b1; thr = 32'h1000;
    @(negedge clk);
    chk("restart_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("restart_node_count", {22'b0, node_count}, 32'd0);
    chk("restart_max_delta", max_delta, 32'd0);
    chk("restart_top_rank", top_rank, 32'd0);
    chk("restart_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    q.push_back('{1'b1, 32'h800, 10'd1, 32'h2000, 10'd2, 1'b0});
    beat(32'h1000, 32'h1800, 1'b0);
    gap($urandom_range(0, 3));
    beat(32'h2000, 32'h2000, 1'b1);
    // index wrap sets overflow
    q.push_back('{1'b1, 32'h0, 10'd500, 32'h9999, 10'd1, 1'b1});
    do_start(32'h0);
    for (int i = 0; i <= 1024; i++)
      beat((i == 500) ? 32'h9999 : 32'h1, (i == 500) ? 32'h9999 : 32'h1, i == 1024);
    do_start(32'h0);
    @(negedge clk);
    chk("start_clears_overflow", {31'b0, overflow}, 32'd0);
    chk("start_clears_count", {22'b0, node_count}, 32'd0);
    @(posedge clk);
    #1;
    // asynchronous reset mid-vector
    for (int i = 0; i < 5; i++) beat(32'h100, 32'h300 + i, 1'b0);
    chk("pre_rst_count", {22'b0, node_count}, 32'd5);
    rst = 1'b1;
    #2;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("arst_max_delta", max_delta, 32'd0);
    chk("arst_top_rank", top_rank, 32'd0);
    chk("arst_top_idx", {22'b0, top_idx}, 32'd0);
    chk("arst_node_count", {22'b0, node_count}, 32'd0);
    chk("arst_converged", {31'b0, converged}, 32'd0);
    chk("arst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_old = 32'h0; in_new = 32'h1234; in_last = 1'b1;
    idle(3);
    @(negedge clk);
    chk("idle_ignores_busy", {31'b0, busy}, 32'd0);
    chk("idle_ignores_count", {22'b0, node_count}, 32'd0);
    chk("idle_ignores_top", top_rank, 32'd0);
    in_valid = 1'b0; in_last = 1'b0;
    idle(5);
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("done_count", dones, 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
